// File: rtl/uart_rx_fpga_if.sv
// rtl/uart_rx_fpga_if.sv - serial line and received-packet signals of the FPGA-side UART receiver
interface uart_rx_fpga_if #(
  parameter int WIDTH = 64
);
  logic             rx_in;
  logic             rx_enable;
  logic [WIDTH-1:0] rx_data;
  logic             rx_data_valid;
  logic             rx_busy;
  logic             frame_error;
  logic             parity_error;

  // Line/transmitter side: drives the serial pin and the clock enable
  modport master (
    output rx_in, rx_enable,
    input  rx_data, rx_data_valid, rx_busy, frame_error, parity_error
  );

  // Receiver side
  modport slave (
    input  rx_in, rx_enable,
    output rx_data, rx_data_valid, rx_busy, frame_error, parity_error
  );
endinterface

// File: rtl/uart_rx_fpga.sv
// rtl/uart_rx_fpga.sv - 2X-oversampled UART receiver for WIDTH-bit packets; UART_RX_PARITY_CHECK_EN enables odd-parity check
module uart_rx_fpga #(
  parameter int WIDTH = 64
) (
  input logic           rxclk,
  input logic           reset_n,
  uart_rx_fpga_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [6:0] LAST_BIT = 7'(WIDTH - 1);

  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [2:0]       state_q, state_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;

  // Next-state logic: synchronizer, frame FSM, bit capture and strobe generation
  always_comb begin
    sync1_d   = bus.rx_in;
    rx_s_d    = sync1_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Second low sample confirms the start bit; a single low sample is a glitch
        if (!rx_s_q) begin
          state_d   = S_DATA;
          busy_d    = 1'b1;
          bit_cnt_d = 7'd0;
          phase_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        phase_d = ~phase_q;
        // Phase 1 is the second half of the bit cell, well clear of the edges
        if (phase_q) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt_q == 7'(i)) shift_d[i] = rx_s_q;
          end
          bit_cnt_d = bit_cnt_q + 7'd1;
          if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          busy_d = 1'b0;
          if (rx_s_q) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
`ifdef UART_RX_PARITY_CHECK_EN
            // Packets carry odd parity, so an even count of ones is an error
            perr_d    = ~(^shift_q);
`endif
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Line held low after a bad stop bit must return high before a new start counts
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; rx_enable low freezes everything including the synchronizer
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= 7'd0;
      phase_q   <= 1'b0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else if (bus.rx_enable) begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Strobes are masked while disabled so a frozen strobe is never seen twice downstream
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_busy       = busy_q;
  assign bus.rx_data_valid = valid_q & bus.rx_enable;
  assign bus.frame_error   = ferr_q & bus.rx_enable;
  assign bus.parity_error  = perr_q & bus.rx_enable;

endmodule

// File: tb/tb_uart_rx_fpga.sv
// tb/tb_uart_rx_fpga.sv - scoreboard bench for uart_rx_fpga
module tb_uart_rx_fpga;

  localparam int WIDTH = 64;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic        perr;
    logic        ferr;
    int          cyc;
  } exp_t;

  logic        rxclk = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] last_good;

  uart_rx_fpga_if #(.WIDTH(WIDTH)) bus ();

  uart_rx_fpga #(.WIDTH(WIDTH)) dut (
    .rxclk   (rxclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic b);
    @(posedge rxclk);
    #1;
    bus.rx_in = b;
  endtask

  // Drives one frame, two rxclk cycles per bit. stall_at/abort_at are half-bit indices (-1 = none).
  task automatic send_frame(input logic [63:0] w, input logic stop_bit,
                            input int stall_at, input int abort_at);
    logic [65:0] sym;
    exp_t        e;
    sym = {stop_bit, w, 1'b0};
    for (int j = 0; j < 132; j++) begin
      if (j == stall_at) begin
        bus.rx_enable = 1'b0;
        repeat (10) @(posedge rxclk);
        #1;
        bus.rx_enable = 1'b1;
      end
      if (j == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_rx_data", bus.rx_data, 64'h0);
        check("rst_busy", {63'h0, bus.rx_busy}, 64'h0);
        check("rst_valid", {63'h0, bus.rx_data_valid}, 64'h0);
        check("rst_frame_error", {63'h0, bus.frame_error}, 64'h0);
        void'(sb.pop_back());
        last_good = 64'h0;
        repeat (3) @(posedge rxclk);
        #1;
        bus.rx_in = 1'b1;
        reset_n   = 1'b1;
        return;
      end
      step(sym[j/2]);
      if (j == 0) begin
        e.data = stop_bit ? w : last_good;
        e.perr = stop_bit & PAR_EN & ~(^w);
        e.ferr = ~stop_bit;
        e.cyc  = cyc + 134 + ((stall_at > 0) ? 10 : 0);
        sb.push_back(e);
        if (stop_bit) last_good = w;
      end
      if (j == 80) check("busy_mid_frame", {63'h0, bus.rx_busy}, 64'h1);
    end
  endtask

  // Output monitor: every strobe must match the oldest expected frame, on time
  always @(negedge rxclk) begin
    if (reset_n === 1'b1) begin
      if (bus.rx_data_valid || bus.frame_error) begin
        if (sb.size() == 0) begin
          check("spurious_strobe", 64'h1, 64'h0);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("frame_error", {63'h0, bus.frame_error}, {63'h0, mon_e.ferr});
          check("data_valid", {63'h0, bus.rx_data_valid}, {63'h0, ~mon_e.ferr});
          check("rx_data", bus.rx_data, mon_e.data);
          check("parity_error", {63'h0, bus.parity_error}, {63'h0, mon_e.perr});
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        check("strobe_missing", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end else if (bus.parity_error) begin
        check("stray_parity_error", 64'h1, 64'h0);
      end
    end
  end

  initial begin
    bus.rx_in     = 1'b1;
    bus.rx_enable = 1'b1;
    reset_n       = 1'b0;
    last_good     = 64'h0;
    repeat (3) @(posedge rxclk);
    #1;
    check("reset_rx_data", bus.rx_data, 64'h0);
    check("reset_valid", {63'h0, bus.rx_data_valid}, 64'h0);
    check("reset_busy", {63'h0, bus.rx_busy}, 64'h0);
    check("reset_frame_error", {63'h0, bus.frame_error}, 64'h0);
    check("reset_parity_error", {63'h0, bus.parity_error}, 64'h0);
    reset_n = 1'b1;
    repeat (4) step(1'b1);

    send_frame(64'h0, 1'b1, -1, -1);
    send_frame(64'h0000_0000_0000_0001, 1'b1, -1, -1);

    send_frame(64'hA5A5_5A5A_0F0F_F0F0, 1'b0, -1, -1);
    repeat (20) step(1'b0);
    check("break_busy", {63'h0, bus.rx_busy}, 64'h0);
    repeat (4) step(1'b1);
    send_frame(64'hDEAD_BEEF_1234_5678, 1'b1, -1, -1);
    repeat (4) step(1'b1);

    step(1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check("glitch_busy", {63'h0, bus.rx_busy}, 64'h0);
    end

    send_frame(64'h0000_0000_0000_0001, 1'b1, -1, -1);
    send_frame(64'h8000_0000_0000_0000, 1'b1, -1, -1);
    send_frame(64'hFFFF_0000_1234_ABCD, 1'b1, -1, 62);
    repeat (4) step(1'b1);
    check("post_reset_rx_data", bus.rx_data, 64'h0);
    check("post_reset_busy", {63'h0, bus.rx_busy}, 64'h0);

    send_frame(64'h0123_4567_89AB_CDEF, 1'b1, -1, -1);
    send_frame({$urandom, $urandom}, 1'b1, 70, -1);
    send_frame({$urandom, $urandom}, 1'b1, -1, -1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge rxclk);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    repeat (5) @(posedge rxclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fpga.md
# uart_rx_fpga

FPGA-side UART receiver for 64-bit chip packets. Samples the serial stream from the chip transmitter with a 2X-oversampled clock (rxclk at twice the TX baud rate), reassembles start bit + 64 data bits LSB-first + stop bit, and presents the word as a one-cycle strobe. It sits between the chip's tx_out pin and the FPGA packet FIFO/decoder.

## Interface
- WIDTH, 64, packet width in bits (bit WIDTH-1 is the odd-parity bit)
- rxclk  in  1  receive clock, 2X the TX baud rate
- reset_n  in  1  asynchronous, active-low reset
- rx_in  in  1  serial line from chip TX; idles high
- rx_enable  in  1  clock-gating enable; low freezes all state
- rx_data  out  WIDTH  last received packet
- rx_data_valid  out  1  one-cycle strobe: rx_data updated
- rx_busy  out  1  high from validated start bit until leaving STOP
- frame_error  out  1  one-cycle strobe: stop bit sampled low
- parity_error  out  1  one-cycle strobe coincident with rx_data_valid when parity fails

## Operation
- rx_in passes a 2-flop synchronizer (flops reset to 1); rx_s is its output. All behaviour below refers to rx_s.
- States: IDLE, START, DATA, STOP, BREAK. Bit counter 7 bits, phase flag 1 bit.
- IDLE: rx_s==0 -> START.
- START: rx_s==0 -> DATA, rx_busy<=1, bit count 0, phase 0; rx_s==1 -> IDLE (glitch rejected, no output).
- DATA: phase toggles every cycle; on phase 1 shift rx_s into bit [count] of a shift register (LSB first), count++. After bit WIDTH-1 -> STOP.
- STOP: sample on phase 1. rx_s==1 -> rx_data<=shift reg, rx_data_valid pulse, IDLE. rx_s==0 -> frame_error pulse, rx_data unchanged, BREAK.
- BREAK: wait for rx_s==1 -> IDLE (no new start detected while line held low).
- rx_busy cleared on exit from STOP.
- No backpressure: rx_data held until next good packet overwrites it.
- rx_enable low: every register (including synchronizer) holds; strobes held are not re-issued — strobe outputs forced 0 while disabled.

## Timing
- Reset values: rx_data=0, rx_data_valid=0, rx_busy=0, frame_error=0, parity_error=0, state IDLE, synchronizer=1.
- Pin-to-rx_s latency: 2 cycles.
- Let t0 = cycle rx_s first seen 0 in IDLE. Start confirmed at t0+1; data bit k sampled at t0+3+2k; bit 63 at t0+129; stop sampled t0+131; rx_data/rx_data_valid/error strobes registered, visible t0+132.
- Back-to-back frames: next start bit may be detected in IDLE at t0+132 (the cycle the strobe is visible).
- Reset asserted mid-frame: immediate return to reset values; partial word discarded.

## Configuration
- UART_RX_PARITY_CHECK_EN defined: at stop-sample cycle compute XOR of all WIDTH received bits; result 0 (even count) -> parity_error pulses with rx_data_valid. Data still delivered.
- Undefined: parity logic omitted; parity_error tied 0; bit 63 delivered as ordinary data.

## Test plan
- Send 64'h0000_0000_0000_0001 framed correctly -> rx_data_valid at t0+132, rx_data=64'h1, parity_error=0, frame_error=0.
- Send 64'h0 with macro defined -> rx_data_valid=1, rx_data=0, parity_error=1 same cycle; macro undefined -> parity_error=0.
- Send 64'hA5A5_5A5A_0F0F_F0F0 with stop bit 0 -> frame_error pulse once, no rx_data_valid, rx_data keeps previous value; line held low 20 cycles then high -> next packet received correctly.
- One-cycle low glitch on rx_in while idle -> no rx_busy, no strobes, state returns IDLE.
- Two packets back-to-back (8'h..01 then 64'h8000_0000_0000_0000) -> two valid strobes 132 cycles apart, both words correct; reset_n pulsed at bit 30 of a third packet -> all outputs 0, no strobe.
- Hold rx_enable low for 10 cycles mid-frame while transmitter also stalls -> resumed frame received with correct data, strobe delayed by 10 cycles.
